// File: rtl/hp_module_if.sv
// Battle-engine HP bus: attack requests from the turn controller and the
// registered HP values / update strobes consumed by the HUD.
interface hp_module_if;
  logic [1:0] attack_p;
  logic [1:0] attack_e;
  logic       att_p_en;
  logic       att_e_en;
  logic [7:0] HP_p;
  logic [7:0] HP_e;
  logic       HP_p_en;
  logic       HP_e_en;

  // Controller / bench side: issues attacks, observes HP.
  modport master (
    output attack_p,
    output attack_e,
    output att_p_en,
    output att_e_en,
    input  HP_p,
    input  HP_e,
    input  HP_p_en,
    input  HP_e_en
  );

  // HP bookkeeping block side.
  modport slave (
    input  attack_p,
    input  attack_e,
    input  att_p_en,
    input  att_e_en,
    output HP_p,
    output HP_e,
    output HP_p_en,
    output HP_e_en
  );
endinterface

// File: rtl/hp_module.sv
// Hit-point bookkeeping: holds player/enemy HP, applies saturating damage on
// the rising edge of each attack enable and pulses a one-cycle update strobe.
module hp_module #(
  parameter int unsigned HP_MAX = 100,
  parameter int unsigned DMG0   = 5,
  parameter int unsigned DMG1   = 10,
  parameter int unsigned DMG2   = 15,
  parameter int unsigned DMG3   = 20
) (
  input  logic        clk,
  input  logic        rst,
  hp_module_if.slave  bus
);

  localparam logic [7:0] HP_INIT = 8'(HP_MAX);

  logic       prev_p;
  logic       prev_e;
  logic       rise_p;
  logic       rise_e;
  logic [7:0] dmg_p;
  logic [7:0] dmg_e;
  logic       hit_p;
  logic       hit_e;
  logic [7:0] hp_p_q;
  logic [7:0] hp_e_q;
  logic [7:0] hp_p_next;
  logic [7:0] hp_e_next;
  logic       stb_p_q;
  logic       stb_e_q;

  function automatic logic [7:0] dmg_lookup(input logic [1:0] code);
    case (code)
      2'b00:   dmg_lookup = 8'(DMG0);
      2'b01:   dmg_lookup = 8'(DMG1);
      2'b10:   dmg_lookup = 8'(DMG2);
      default: dmg_lookup = 8'(DMG3);
    endcase
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    sat_sub = (hp > dmg) ? hp - dmg : '0;
  endfunction

  // Enable history: a cleared history makes an enable held through reset
  // count as a rise on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_p <= 1'b0;
      prev_e <= 1'b0;
    end else begin
      prev_p <= bus.att_p_en;
      prev_e <= bus.att_e_en;
    end
  end

  // Hit detection and damage; a hit on a combatant already at 0 is dropped.
  always_comb begin
    rise_p    = bus.att_p_en & ~prev_p;
    rise_e    = bus.att_e_en & ~prev_e;
    dmg_p     = dmg_lookup(bus.attack_p);
    dmg_e     = dmg_lookup(bus.attack_e);
    hit_p     = rise_p && (hp_e_q != '0);
    hit_e     = rise_e && (hp_p_q != '0);
    hp_e_next = hit_p ? sat_sub(hp_e_q, dmg_p) : hp_e_q;
    hp_p_next = hit_e ? sat_sub(hp_p_q, dmg_e) : hp_p_q;
  end

  // HP registers and update strobes; player attacks hit the enemy and
  // enemy attacks hit the player, each independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_p_q  <= HP_INIT;
      hp_e_q  <= HP_INIT;
      stb_p_q <= 1'b0;
      stb_e_q <= 1'b0;
    end else begin
      hp_p_q  <= hp_p_next;
      hp_e_q  <= hp_e_next;
      stb_p_q <= hit_e;
      stb_e_q <= hit_p;
    end
  end

  assign bus.HP_p    = hp_p_q;
  assign bus.HP_e    = hp_e_q;
  assign bus.HP_p_en = stb_p_q;
  assign bus.HP_e_en = stb_e_q;

endmodule

// File: tb/tb_hp_module.sv
// Self-checking bench for hp_module: behavioural HP model checked every
// negative edge, directed literal scenarios, then randomized attacks/resets.
module tb_hp_module;

  logic clk;
  logic rst;
  hp_module_if bus ();

  hp_module #(
    .HP_MAX(100), .DMG0(5), .DMG1(10), .DMG2(15), .DMG3(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: HP as plain integers, damage table, "was the enable
  // low last time I looked" flags.
  int dmg_tab [4] = '{5, 10, 15, 20};
  int m_hp_p, m_hp_e;
  bit m_seen_p, m_seen_e;
  bit m_stb_p, m_stb_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hp_p = 100; m_hp_e = 100;
      m_seen_p = 0; m_seen_e = 0;
      m_stb_p = 0; m_stb_e = 0;
    end else begin
      m_stb_p = 0; m_stb_e = 0;
      if (bus.att_p_en && !m_seen_p && m_hp_e > 0) begin
        m_hp_e = m_hp_e - dmg_tab[bus.attack_p];
        if (m_hp_e < 0) m_hp_e = 0;
        m_stb_e = 1;
      end
      if (bus.att_e_en && !m_seen_e && m_hp_p > 0) begin
        m_hp_p = m_hp_p - dmg_tab[bus.attack_e];
        if (m_hp_p < 0) m_hp_p = 0;
        m_stb_p = 1;
      end
      m_seen_p = bus.att_p_en;
      m_seen_e = bus.att_e_en;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if (int'(bus.HP_p) != m_hp_p || int'(bus.HP_e) != m_hp_e ||
        bus.HP_p_en !== m_stb_p || bus.HP_e_en !== m_stb_e) begin
      errors++;
      $display("FAIL model t=%0t: got HP_p=%0d HP_e=%0d p_en=%b e_en=%b, want %0d %0d %b %b",
               $time, bus.HP_p, bus.HP_e, bus.HP_p_en, bus.HP_e_en,
               m_hp_p, m_hp_e, m_stb_p, m_stb_e);
    end
  end

  task automatic lit(input string name, input int hp_p, input int hp_e,
                     input bit sp, input bit se);
    checks++;
    if (int'(bus.HP_p) != hp_p || int'(bus.HP_e) != hp_e ||
        bus.HP_p_en !== sp || bus.HP_e_en !== se) begin
      errors++;
      $display("FAIL %s: got HP_p=%0d HP_e=%0d p_en=%b e_en=%b, want %0d %0d %b %b",
               name, bus.HP_p, bus.HP_e, bus.HP_p_en, bus.HP_e_en, hp_p, hp_e, sp, se);
    end
  endtask

  // Advance n clocks; return 2 time units after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges; HP must restore immediately.
  task automatic do_reset(input bit keep_en);
    #1 rst = 1'b1;
    #1 lit("async_reset", 100, 100, 0, 0);
    if (!keep_en) begin
      bus.att_p_en = 0;
      bus.att_e_en = 0;
    end
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pulse_p(input logic [1:0] code);
    bus.attack_p = code; bus.att_p_en = 1; tick(1);
  endtask

  task automatic pulse_e(input logic [1:0] code);
    bus.attack_e = code; bus.att_e_en = 1; tick(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.attack_p = '0; bus.attack_e = '0;
    bus.att_p_en = 0;  bus.att_e_en = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    lit("reset_state", 100, 100, 0, 0);

    // Enemy code 00 held high for 5 cycles: one hit only.
    pulse_e(2'b00);
    lit("e_hit_00", 95, 100, 1, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick(1);
      lit("e_hold_no_rehit", 95, 100, 0, 0);
    end
    bus.att_e_en = 0;
    pulse_p(2'b01);
    lit("p_hit_01", 95, 90, 0, 1);
    tick(1);
    lit("p_strobe_single", 95, 90, 0, 0);
    bus.att_p_en = 0;
    pulse_e(2'b10);
    lit("e_hit_10", 80, 90, 1, 0);
    bus.att_e_en = 0; tick(1);
    pulse_p(2'b11);
    lit("p_hit_11", 80, 70, 0, 1);
    bus.att_p_en = 0; tick(1);
    pulse_e(2'b10);
    lit("e_hit_10_again", 65, 70, 1, 0);
    bus.att_e_en = 0; tick(1);

    // Saturation: drive HP_e to 15, then to 0, then a dropped hit.
    do_reset(0);
    for (int unsigned i = 0; i < 4; i++) begin
      pulse_p(2'b11); bus.att_p_en = 0; tick(1);
    end
    pulse_p(2'b00); bus.att_p_en = 0; tick(1);
    lit("sat_pre_15", 100, 15, 0, 0);
    pulse_p(2'b11);
    lit("sat_to_zero", 100, 0, 0, 1);
    bus.att_p_en = 0; tick(1);
    pulse_p(2'b11);
    lit("hit_at_zero_ignored", 100, 0, 0, 0);
    bus.att_p_en = 0; tick(1);

    // Simultaneous rises.
    do_reset(0);
    bus.attack_p = 2'b00; bus.attack_e = 2'b11;
    bus.att_p_en = 1; bus.att_e_en = 1;
    tick(1);
    lit("simultaneous", 80, 95, 1, 1);
    bus.att_p_en = 0; bus.att_e_en = 0; tick(1);

    // Enable held through reset release counts as a rise.
    bus.attack_p = 2'b00; bus.att_p_en = 1;
    do_reset(1);
    tick(1);
    lit("en_high_at_release", 100, 95, 0, 1);
    bus.att_p_en = 0; tick(1);

    // Randomized phase.
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        bus.attack_p = 2'($urandom);
        bus.attack_e = 2'($urandom);
        if ($urandom_range(0, 2) == 0) bus.att_p_en = ~bus.att_p_en;
        if ($urandom_range(0, 2) == 0) bus.att_e_en = ~bus.att_e_en;
        tick(1);
      end
    end

    bus.att_p_en = 0; bus.att_e_en = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
